// File: rtl/matmul_output_drain.sv
//------------------------------------------------------------------------------
// Module      : matmul_output_drain
// Description : Snapshots a completed ROWS x COLS output matrix on capture_req
//               and streams it row-major over valid/ready with row/col tags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif

module matmul_output_drain #(
    parameter int WORD_SIZE = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WORD_SIZE-1:0]       output_matrix [`ROWS][`COLS],
    input  logic                       capture_req,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WORD_SIZE-1:0]       out_data,
    output logic [$clog2(`ROWS):0]     out_row,
    output logic [$clog2(`COLS):0]     out_col,
    output logic                       out_last,
    output logic                       busy,
    output logic                       overrun
);

    localparam int NROWS = `ROWS;
    localparam int NCOLS = `COLS;
    localparam int RW    = $clog2(`ROWS) + 1;
    localparam int CW    = $clog2(`COLS) + 1;

    localparam logic [RW-1:0] LAST_ROW = RW'(NROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CW-1:0]          col_q, col_d;
    logic                   overrun_q, overrun_d;
    logic [WORD_SIZE-1:0]   snap_q [NROWS][NCOLS];

    logic                   w_load;
    logic                   w_xfer;
    logic                   w_at_last;

    assign w_xfer    = (state_q == S_DRAIN) && out_ready;
    assign w_at_last = (row_q == LAST_ROW) && (col_q == LAST_COL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
            for (int r = 0; r < NROWS; r++) begin
                for (int c = 0; c < NCOLS; c++) begin
                    snap_q[r][c] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
            if (w_load) begin
                for (int r = 0; r < NROWS; r++) begin
                    for (int c = 0; c < NCOLS; c++) begin
                        snap_q[r][c] <= output_matrix[r][c];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;
        w_load    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (capture_req) begin
                    w_load  = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_xfer) begin
                    if (w_at_last) begin
                        row_d = '0;
                        col_d = '0;
                        // A capture coinciding with the final beat chains the next matrix with no bubble
                        if (capture_req) begin
                            w_load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (capture_req && !(w_xfer && w_at_last)) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Element select by comparison keeps index widths exact for any ROWS/COLS
    always_comb begin
        out_data = '0;
        for (int r = 0; r < NROWS; r++) begin
            for (int c = 0; c < NCOLS; c++) begin
                if ((state_q == S_DRAIN) && (row_q == RW'(r)) && (col_q == CW'(c))) begin
                    out_data = snap_q[r][c];
                end
            end
        end
    end

    assign out_valid = (state_q == S_DRAIN);
    assign busy      = (state_q == S_DRAIN);
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = w_at_last && out_valid;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire
